// File: rtl/pad_bus_controller.sv
// External bus adapter: turns core phase strobes into single req/ack bus transactions with
// byte lanes, store replication and load alignment. Optional timeout: define PAD_BUS_TIMEOUT_EN.
module pad_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pad_write_address,
  input  logic        pad_read,
  input  logic        pad_write,
  input  logic [1:0]  pad_data_size,
  input  logic [31:0] core_data_out,
  output logic [31:0] core_data_in,
  output logic        stall,
  output logic        misaligned,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  output logic        bus_request,
  output logic        bus_write,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack,
  output logic        bus_error
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] addr;
  logic [31:0] access_addr;
  logic [1:0]  offset;
  logic [1:0]  size;
  logic        start;
  logic        launch;
  logic        complete;
  logic        timeout;
  logic        lane_misaligned;
  logic [3:0]  lanes;
  logic [31:0] write_data;
  logic [31:0] read_aligned;

  assign start       = pad_read | pad_write;
  // An address strobe in the same cycle as a read/write feeds the access directly.
  assign access_addr = pad_write_address ? core_data_out : addr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lanes           = 4'b1111;
    write_data      = core_data_out;
    lane_misaligned = 1'b0;
    case (pad_data_size)
      2'b00: begin
        lanes      = 4'b0001 << access_addr[1:0];
        write_data = {4{core_data_out[7:0]}};
      end
      2'b01: begin
        lanes           = 4'b0011 << {access_addr[1], 1'b0};
        write_data      = {2{core_data_out[15:0]}};
        lane_misaligned = access_addr[0];
      end
      default: lane_misaligned = |access_addr[1:0];
    endcase
  end

  always_comb begin
    read_aligned = bus_read_data;
    case (size)
      2'b00:   read_aligned = {24'h0, 8'(bus_read_data >> {offset, 3'b000})};
      2'b01:   read_aligned = {16'h0, 16'(bus_read_data >> {offset[1], 4'b0000})};
      default: read_aligned = bus_read_data;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    launch     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall      = 1'b1;
          launch     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_request = (state == WAIT);
  assign misaligned  = launch & lane_misaligned;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr            <= '0;
      bus_address     <= '0;
      bus_byte_enable <= '0;
      bus_write_data  <= '0;
      bus_write       <= 1'b0;
      offset          <= '0;
      size            <= '0;
      core_data_in    <= '0;
    end else begin
      if (pad_write_address) addr <= core_data_out;
      if (launch) begin
        bus_write       <= pad_write;
        size            <= pad_data_size;
        offset          <= access_addr[1:0];
        bus_address     <= {access_addr[31:2], 2'b00};
        bus_byte_enable <= lanes;
        bus_write_data  <= write_data;
      end
      if (complete && !bus_write)     core_data_in <= read_aligned;
      else if (timeout && !bus_write) core_data_in <= '0;
    end
  end

`ifdef PAD_BUS_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] timer;

  // Abort in the last allowed WAIT cycle so stall releases at the same edge as the return to IDLE.
  assign timeout = (state == WAIT) & ~bus_ack & (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      timer     <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= timeout;
      if (launch)              timer <= '0;
      else if (state == WAIT)  timer <= timer + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
  assign bus_error          = 1'b0;
`endif

endmodule

// File: tb/tb_pad_bus_controller.sv
// Self-checking bench for pad_bus_controller: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pad_bus_controller;

  localparam int TB_TIMEOUT = 4;

  logic        clock;
  logic        reset;
  logic        pad_write_address;
  logic        pad_read;
  logic        pad_write;
  logic [1:0]  pad_data_size;
  logic [31:0] core_data_out;
  logic [31:0] core_data_in;
  logic        stall;
  logic        misaligned;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_read_data;
  logic        bus_ack;
  logic        bus_error;

  int n_cmp  = 0;
  int n_fail = 0;
  int stall_cnt;
  logic model_on = 1'b0;

  pad_bus_controller #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock             (clock),
    .reset             (reset),
    .pad_write_address (pad_write_address),
    .pad_read          (pad_read),
    .pad_write         (pad_write),
    .pad_data_size     (pad_data_size),
    .core_data_out     (core_data_out),
    .core_data_in      (core_data_in),
    .stall             (stall),
    .misaligned        (misaligned),
    .bus_address       (bus_address),
    .bus_byte_enable   (bus_byte_enable),
    .bus_write_data    (bus_write_data),
    .bus_request       (bus_request),
    .bus_write         (bus_write),
    .bus_read_data     (bus_read_data),
    .bus_ack           (bus_ack),
    .bus_error         (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] exp_lanes(input logic [1:0] sz, input logic [1:0] a);
    int n;
    if (sz == 2'b00)      n = 1 << a;
    else if (sz == 2'b01) n = 3 << (a & 2'b10);
    else                  n = 15;
    return 4'(n);
  endfunction

  function automatic logic exp_misaligned(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return a != 0;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (sz == 2'b01) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] sz, input logic [1:0] a,
                                            input logic [31:0] r);
    logic [31:0] s;
    if (sz == 2'b00) begin
      s = r >> (8 * a);
      return s & 32'h0000_00FF;
    end
    if (sz == 2'b01) begin
      s = r >> (8 * (a & 2'b10));
      return s & 32'h0000_FFFF;
    end
    return r;
  endfunction

  logic        m_busy  = 1'b0;
  logic        m_write = 1'b0;
  logic [1:0]  m_size  = '0;
  logic [1:0]  m_off   = '0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_baddr = '0;
  logic [3:0]  m_be    = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_cdi   = '0;
  logic        m_err   = 1'b0;
  int          m_cnt   = 0;

  always @(negedge clock) begin
    logic [31:0] eff;
    logic        start;
    logic        tmo;
    logic        e_stall;
    logic        e_mis;
    if (model_on) begin
      start = pad_read | pad_write;
      eff   = pad_write_address ? core_data_out : m_addr;
`ifdef PAD_BUS_TIMEOUT_EN
      tmo = m_busy && !bus_ack && (m_cnt == TB_TIMEOUT - 1);
`else
      tmo = 1'b0;
`endif
      e_stall = m_busy ? (!bus_ack && !tmo) : start;
      e_mis   = !m_busy && start && exp_misaligned(pad_data_size, eff[1:0]);

      check("stall", {31'h0, stall}, {31'h0, e_stall});
      check("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
      check("bus_request", {31'h0, bus_request}, {31'h0, m_busy});
      check("core_data_in", core_data_in, m_cdi);
      check("bus_error", {31'h0, bus_error}, {31'h0, m_err});
      if (m_busy) begin
        check("bus_address", bus_address, m_baddr);
        check("bus_byte_enable", {28'h0, bus_byte_enable}, {28'h0, m_be});
        check("bus_write", {31'h0, bus_write}, {31'h0, m_write});
        if (m_write) check("bus_write_data", bus_write_data, m_wdata);
      end

      if (reset) begin
        m_busy = 1'b0; m_write = 1'b0; m_addr = '0; m_cdi = '0; m_err = 1'b0; m_cnt = 0;
      end else begin
        m_err = tmo;
        if (m_busy) begin
          if (bus_ack) begin
            m_busy = 1'b0;
            if (!m_write) m_cdi = exp_rdata(m_size, m_off, bus_read_data);
          end else if (tmo) begin
            m_busy = 1'b0;
            if (!m_write) m_cdi = '0;
          end else begin
            m_cnt++;
          end
        end else if (start) begin
          m_busy  = 1'b1;
          m_write = pad_write;
          m_size  = pad_data_size;
          m_off   = eff[1:0];
          m_baddr = eff & ~32'h3;
          m_be    = exp_lanes(pad_data_size, eff[1:0]);
          m_wdata = exp_wdata(pad_data_size, core_data_out);
          m_cnt   = 0;
        end
        if (pad_write_address) m_addr = core_data_out;
      end
    end
  end

  // ---------------- stimulus ----------------
  // One cycle of inputs; returns shortly after they settle so literal checks see this cycle.
  task automatic drive(input logic pwa, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] d, input logic ack, input logic [31:0] rdata);
    @(posedge clock);
    #1;
    pad_write_address = pwa;
    pad_read          = rd;
    pad_write         = wr;
    pad_data_size     = sz;
    core_data_out     = d;
    bus_ack           = ack;
    bus_read_data     = rdata;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    pad_write_address = 1'b0; pad_read = 1'b0; pad_write = 1'b0;
    pad_data_size = 2'b00; core_data_out = '0; bus_read_data = '0; bus_ack = 1'b0;
    @(posedge clock);
    #1 model_on = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    #2;
    check("rst_core_data_in", core_data_in, 32'h0);
    check("rst_bus_request", {31'h0, bus_request}, 32'h0);
    check("rst_bus_address", bus_address, 32'h0);
    check("rst_byte_enable", {28'h0, bus_byte_enable}, 32'h0);
    check("rst_bus_write_data", bus_write_data, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_bus_error", {31'h0, bus_error}, 32'h0);

    // 1: byte read at 0x1000_0002, ack after three wait cycles
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h1000_0002, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    stall_cnt = int'(stall);
    for (int i = 0; i < 3; i++) begin
      idle();
      stall_cnt += int'(stall);
      check("t1_byte_enable", {28'h0, bus_byte_enable}, 32'h4);
      check("t1_bus_address", bus_address, 32'h1000_0000);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'hAABB_CCDD);
    stall_cnt += int'(stall);
    idle();
    check("t1_core_data_in", core_data_in, 32'h0000_00BB);
    check("t1_stall_cycles", stall_cnt, 32'd4);

    // 2: half write at 0x20, immediate ack
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h20, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 2'b01, 32'h1234, 1'b0, 32'h0);
    check("t2_stall_strobe", {31'h0, stall}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h0);
    check("t2_bus_write_data", bus_write_data, 32'h1234_1234);
    check("t2_byte_enable", {28'h0, bus_byte_enable}, 32'h3);
    check("t2_stall_ack", {31'h0, stall}, 32'h0);
    idle();
    check("t2_request_dropped", {31'h0, bus_request}, 32'h0);
    check("t2_core_data_held", core_data_in, 32'h0000_00BB);

    // 3: misaligned word read at 0x101
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h101, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0, 32'h0);
    check("t3_misaligned", {31'h0, misaligned}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h1122_3344);
    check("t3_misaligned_pulse", {31'h0, misaligned}, 32'h0);
    check("t3_bus_address", bus_address, 32'h100);
    check("t3_byte_enable", {28'h0, bus_byte_enable}, 32'hF);
    idle();
    check("t3_core_data_in", core_data_in, 32'h1122_3344);

    // 4: address bypass with half read
    drive(1'b1, 1'b1, 1'b0, 2'b01, 32'h40, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'hCAFE_BABE);
    check("t4_bus_address", bus_address, 32'h40);
    idle();
    check("t4_core_data_in", core_data_in, 32'h0000_BABE);

    // Write priority, lane 3 byte store, then back-to-back misaligned half read
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h43, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_00A5, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h0);
    check("prio_bus_write", {31'h0, bus_write}, 32'h1);
    check("byte_wdata", bus_write_data, 32'hA5A5_A5A5);
    check("byte_lane3", {28'h0, bus_byte_enable}, 32'h8);
    drive(1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 1'b0, 32'h0);
    check("b2b_stall", {31'h0, stall}, 32'h1);
    check("half_misaligned", {31'h0, misaligned}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'hCAFE_BABE);
    check("half_hi_lanes", {28'h0, bus_byte_enable}, 32'hC);
    idle();
    check("half_hi_data", core_data_in, 32'h0000_CAFE);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'hFFFF_FFFF);
    check("idle_ack_request", {31'h0, bus_request}, 32'h0);
    idle();
    check("idle_ack_data", core_data_in, 32'h0000_CAFE);

    // 5: reset while waiting
    drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h80, 1'b0, 32'h0);
    idle();
    check("t5_request_wait", {31'h0, bus_request}, 32'h1);
    @(posedge clock);
    #1 reset = 1'b1;
    #2;
    @(posedge clock);
    #1 reset = 1'b0;
    #2;
    check("t5_request", {31'h0, bus_request}, 32'h0);
    check("t5_stall", {31'h0, stall}, 32'h0);
    check("t5_core_data_in", core_data_in, 32'h0);

`ifdef PAD_BUS_TIMEOUT_EN
    // 6: timeout abort of a read
    drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h5555_AAAA);
    idle();
    check("t6_preload", core_data_in, 32'h5555_AAAA);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      idle();
      check("t6_wait_stall", {31'h0, stall}, (i == TB_TIMEOUT - 1) ? 32'h0 : 32'h1);
    end
    idle();
    check("t6_bus_error", {31'h0, bus_error}, 32'h1);
    check("t6_request", {31'h0, bus_request}, 32'h0);
    check("t6_core_data_in", core_data_in, 32'h0);
    idle();
    check("t6_error_pulse", {31'h0, bus_error}, 32'h0);
`endif

    idle();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
